// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction-fetch stage; owns the PC, reads imem over req/ack, presents words to decode.
// Latency: ack in the first request cycle gives instr_valid on the next cycle; at most 1 instr per 2 cycles.
// Backpressure: Instr/PC_out/PC_plus4 hold while instr_ready=0; no new request is issued until it is consumed.
//
// Ports:
//   CLK, reset (async, active-low)
//   imem_req/imem_addr out, imem_ack/imem_data in     : instruction memory read handshake
//   instr_valid out, instr_ready in                    : decode handshake
//   Instr, PC_out, PC_plus4 out                        : fetched word, its address, address + PC_STEP
//   redirect, redirect_pc in                           : branch/jump target load (low 2 bits cleared)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic        run;            // low only in the first cycle after reset release
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] pc_inc;
    logic [31:0] tgt;
    logic        cap;
    logic        valid_nxt;

    assign pc_inc = pc + PC_STEP;                    // wraps modulo 2^32
    assign tgt    = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        valid_nxt      = instr_valid;
        cap            = 1'b0;
        imem_req       = 1'b0;
        imem_addr      = pc;
        case (state)
            FETCH: begin
                imem_req = run;
                if (redirect) begin
                    // A redirect always wins: returned data is dropped, and a
                    // request that is still outstanding has to be drained.
                    pc_nxt = tgt;
                    if (run && !imem_ack) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc;
                    end
                end else if (run && imem_ack) begin
                    cap       = 1'b1;
                    pc_nxt    = pc_inc;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = tgt;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                // Keep presenting the abandoned address until memory answers;
                // pc already holds the newest target.
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                valid_nxt = 1'b0;
                if (redirect) pc_nxt = tgt;
                if (imem_ack) state_nxt = FETCH;
            end
            default: begin
                state_nxt = FETCH;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            run         <= 1'b0;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            instr_valid <= 1'b0;
            Instr       <= 32'd0;
            PC_out      <= 32'd0;
            PC_plus4    <= 32'd0;
        end else begin
            state       <= state_nxt;
            run         <= 1'b1;
            pc          <= pc_nxt;
            drain_addr  <= drain_addr_nxt;
            instr_valid <= valid_nxt;
            if (cap) begin
                Instr    <= imem_data;
                PC_out   <= pc;
                PC_plus4 <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: randomized scoreboard bench for fetch_stage with a transaction-level memory/PC model.
// Latency: n/a (testbench).
// Backpressure: drives random instr_ready stalls and memory ack delays.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 CLK = ~CLK;

    fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .CLK(CLK), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(Instr), .PC_out(PC_out), .PC_plus4(PC_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every instruction decode actually accepts must match the oldest expected one.
    item_t e;
    initial begin
        forever begin
            @(negedge CLK);
            if (reset && instr_valid && instr_ready && !redirect) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc_out %h, nothing expected", PC_out);
                end else begin
                    e = sb.pop_front();
                    chk("instr", Instr, e.ins);
                    chk("pc_out", PC_out, e.pc);
                    chk("pc_plus4", PC_plus4, e.pc4);
                end
            end
        end
    end

    // Reference model state: next address a fresh request must use, whether an
    // instruction is being held for decode, and the in-flight memory request.
    logic [31:0] exp_next, req_addr;
    logic        held, outst, stale, rst_done, redir_done;
    int          cnt, dly, min_dly, max_dly, ready_pct, redir_pct;

    initial begin
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = 32'd0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        exp_next    = RST_PC;
        req_addr    = 32'd0;
        held        = 1'b0;
        outst       = 1'b0;
        stale       = 1'b0;
        rst_done    = 1'b0;
        redir_done  = 1'b0;
        cnt         = 0;
        dly         = 0;

        #3;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_pc_out", PC_out, 32'd0);
        chk("rst_pc_plus4", PC_plus4, 32'd0);
        #9 reset = 1'b1;

        for (int i = 0; i < 600; i++) begin
            @(posedge CLK);
            #1;
            if (i < 20)      begin min_dly = 0; max_dly = 0; ready_pct = 100; redir_pct = 0;  end
            else if (i < 40) begin min_dly = 3; max_dly = 3; ready_pct = 100; redir_pct = 0;  end
            else if (i < 60) begin min_dly = 0; max_dly = 0; ready_pct = (i >= 42 && i < 48) ? 0 : 100; redir_pct = 0; end
            else if (i < 80) begin min_dly = 3; max_dly = 3; ready_pct = 100; redir_pct = 0;  end
            else             begin min_dly = 0; max_dly = 3; ready_pct = 60;  redir_pct = 12; end

            // Asynchronous reset between edges while a request is outstanding.
            if (i >= 300 && !rst_done && imem_req) begin
                rst_done    = 1'b1;
                imem_ack    = 1'b0;
                redirect    = 1'b0;
                instr_ready = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("mid_rst_req", 32'(imem_req), 32'd0);
                chk("mid_rst_valid", 32'(instr_valid), 32'd0);
                chk("mid_rst_pc_out", PC_out, 32'd0);
                sb.delete();
                held     = 1'b0;
                outst    = 1'b0;
                stale    = 1'b0;
                exp_next = RST_PC;
                @(posedge CLK);
                #2 reset = 1'b1;
                continue;
            end

            chk("valid", 32'(instr_valid), 32'(held));
            chk("req", 32'(imem_req), 32'(!held));

            imem_ack = 1'b0;
            if (imem_req) begin
                if (!outst) begin
                    chk("req_addr", imem_addr, exp_next);
                    outst    = 1'b1;
                    stale    = 1'b0;
                    req_addr = exp_next;
                    cnt      = 0;
                    dly      = $urandom_range(max_dly, min_dly);
                end else begin
                    chk("addr_stable", imem_addr, req_addr);
                end
                imem_ack = (cnt == dly);
                cnt++;
            end
            imem_data   = $urandom;
            instr_ready = ($urandom_range(99, 0) < ready_pct);
            redirect    = ($urandom_range(99, 0) < redir_pct);
            redirect_pc = $urandom;
            if (i >= 60 && i < 80 && !redir_done && imem_req && !imem_ack) begin
                redir_done  = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0103;
            end

            // Predict the effect of the coming edge.
            if (held) begin
                if (redirect) begin
                    sb.delete(sb.size() - 1);
                    held = 1'b0;
                end else if (instr_ready) begin
                    held = 1'b0;
                end
            end
            if (imem_req && redirect) stale = 1'b1;
            if (imem_ack) begin
                outst = 1'b0;
                if (!stale) begin
                    sb.push_back('{ins: imem_data, pc: req_addr, pc4: req_addr + 32'd4});
                    held     = 1'b1;
                    exp_next = req_addr + 32'd4;
                end
            end
            if (redirect) exp_next = redirect_pc & 32'hFFFF_FFFC;
        end

        @(posedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
